// File: rtl/pio_loader.sv
// rtl/pio_loader.sv - PIO configuration sequencer
// Streams a program from ROM into PIO instruction memory, then programs one state machine.
module pio_loader #(
  parameter int MAX_LEN = 32,
  parameter int AW      = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [5:0]    i_plen,
  input  logic [1:0]    i_mach,
  input  logic [31:0]   i_exec_ctrl,
  input  logic [23:0]   i_div,
  input  logic [31:0]   i_pin_grps,
  input  logic [3:0]    i_en_mask,
  output logic [AW-1:0] o_prog_addr,
  input  logic [15:0]   i_prog_data,
  output logic [3:0]    o_action,
  output logic [4:0]    o_index,
  output logic [1:0]    o_mindex,
  output logic [31:0]   o_din,
  output logic          o_busy,
  output logic          o_done
);

  localparam int LW = AW + 1;

  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PEND  = 4'd2;
  localparam logic [3:0] ACT_GRPS  = 4'd5;
  localparam logic [3:0] ACT_EN    = 4'd6;
  localparam logic [3:0] ACT_DIV   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_INSTR, S_PEND, S_DIV, S_GRPS, S_EN, S_DONE
  } state_t;

  state_t        r_state, w_state;
  logic [LW-1:0] r_len, r_ctr, w_ctr;
  logic [1:0]    r_mach;
  logic [31:0]   r_exec;
  logic [23:0]   r_div;
  logic [31:0]   r_grps;
  logic [3:0]    r_en;
  logic [AW-1:0] r_addr, w_addr;
  logic [3:0]    r_action, w_action;
  logic [4:0]    r_index, w_index;
  logic [1:0]    r_mindex, w_mindex;
  logic [31:0]   r_din, w_din;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          w_latch;
  logic [LW-1:0] w_len_clamp;
  logic [LW-1:0] w_ctr_inc;

  assign w_len_clamp = (int'(i_plen) > MAX_LEN) ? LW'(MAX_LEN) : LW'(i_plen);
  assign w_ctr_inc   = r_ctr + LW'(1);

  // FETCH is the single gate for leaving the load loop, so len=0 and the
  // final instruction both pass through one quiet cycle before PEND.
  always_comb begin
    w_state  = r_state;
    w_ctr    = r_ctr;
    w_addr   = r_addr;
    w_action = ACT_NONE;
    w_index  = r_index;
    w_mindex = r_mindex;
    w_din    = r_din;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_latch  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_latch = 1'b1;
          w_busy  = 1'b1;
          w_ctr   = '0;
          w_addr  = '0;
          w_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state = (r_ctr == r_len) ? S_PEND : S_INSTR;
      end
      S_INSTR: begin
        w_action = ACT_INSTR;
        w_index  = 5'(r_ctr);
        w_din    = {16'h0, i_prog_data};
        w_mindex = r_mach;
        w_ctr    = w_ctr_inc;
        if (w_ctr_inc < r_len) w_addr = AW'(w_ctr_inc);
        w_state  = S_FETCH;
      end
      S_PEND: begin
        w_action = ACT_PEND;
        w_mindex = r_mach;
        w_din    = r_exec;
        w_state  = S_DIV;
      end
      S_DIV: begin
        w_action = ACT_DIV;
        w_mindex = r_mach;
        w_din    = {8'h0, r_div};
        w_state  = S_GRPS;
      end
      S_GRPS: begin
        w_action = ACT_GRPS;
        w_mindex = r_mach;
        w_din    = r_grps;
        w_state  = S_EN;
      end
      S_EN: begin
        w_action = ACT_EN;
        w_din    = {28'h0, r_en};
        w_state  = S_DONE;
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_ctr    <= '0;
      r_mach   <= '0;
      r_exec   <= '0;
      r_div    <= '0;
      r_grps   <= '0;
      r_en     <= '0;
      r_addr   <= '0;
      r_action <= ACT_NONE;
      r_index  <= '0;
      r_mindex <= '0;
      r_din    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ctr    <= w_ctr;
      r_addr   <= w_addr;
      r_action <= w_action;
      r_index  <= w_index;
      r_mindex <= w_mindex;
      r_din    <= w_din;
      r_busy   <= w_busy;
      r_done   <= w_done;
      if (w_latch) begin
        r_len  <= w_len_clamp;
        r_mach <= i_mach;
        r_exec <= i_exec_ctrl;
        r_div  <= i_div;
        r_grps <= i_pin_grps;
        r_en   <= i_en_mask;
      end
    end
  end

  assign o_prog_addr = r_addr;
  assign o_action    = r_action;
  assign o_index     = r_index;
  assign o_mindex    = r_mindex;
  assign o_din       = r_din;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_pio_loader.sv
// tb/tb_pio_loader.sv - randomized bench for pio_loader against a sequence-level model
module tb_pio_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  plen = '0;
  logic [1:0]  mach = '0;
  logic [31:0] exec_ctrl = '0;
  logic [23:0] div_v = '0;
  logic [31:0] pin_grps = '0;
  logic [3:0]  en_mask = '0;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data = '0;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic        busy, done;

  pio_loader dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_plen(plen), .i_mach(mach),
    .i_exec_ctrl(exec_ctrl), .i_div(div_v), .i_pin_grps(pin_grps), .i_en_mask(en_mask),
    .o_prog_addr(prog_addr), .i_prog_data(prog_data), .o_action(action), .o_index(index),
    .o_mindex(mindex), .o_din(din), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [32];
  always @(posedge clk) prog_data <= rom[prog_addr];

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Sequence-level model: the output timeline is a function of cycles since the accepted start.
  int          cyc = 0;
  int          s_cap = 0;
  bit          m_active = 0;
  int          m_t, m_l, m_k;
  logic [1:0]  m_mach;
  logic [31:0] m_exec, m_grps;
  logic [23:0] m_div;
  logic [3:0]  m_en;
  logic [3:0]  e_action = 0;
  logic [4:0]  e_index = 0, e_addr = 0;
  logic [1:0]  e_mindex = 0;
  logic [31:0] e_din = 0;
  logic        e_busy = 0, e_done = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0;
      e_action = 0; e_index = 0; e_addr = 0; e_mindex = 0; e_din = 0; e_busy = 0; e_done = 0;
    end else begin
      cyc++;
      e_action = 0;
      e_done = 0;
      if (m_active) begin
        m_t++;
        if (m_t % 2 == 0 && m_t >= 2 && m_t <= 2 * m_l) begin
          m_k = (m_t - 2) / 2;
          e_action = 1; e_index = 5'(m_k); e_din = {16'h0, rom[m_k]}; e_mindex = m_mach;
          if (m_k + 1 < m_l) e_addr = 5'(m_k + 1);
        end else if (m_t == 2 * m_l + 2) begin
          e_action = 2; e_din = m_exec; e_mindex = m_mach;
        end else if (m_t == 2 * m_l + 3) begin
          e_action = 7; e_din = {8'h0, m_div}; e_mindex = m_mach;
        end else if (m_t == 2 * m_l + 4) begin
          e_action = 5; e_din = m_grps; e_mindex = m_mach;
        end else if (m_t == 2 * m_l + 5) begin
          e_action = 6; e_din = {28'h0, m_en};
        end else if (m_t == 2 * m_l + 6) begin
          e_done = 1;
        end else if (m_t == 2 * m_l + 7) begin
          e_busy = 0; m_active = 0;
        end
      end else begin
        e_busy = 0;
        if (start) begin
          m_active = 1; m_t = 0; s_cap = cyc;
          m_l = (int'(plen) > 32) ? 32 : int'(plen);
          m_mach = mach; m_exec = exec_ctrl; m_div = div_v; m_grps = pin_grps; m_en = en_mask;
          e_busy = 1; e_addr = 0;
        end
      end
    end
  end

  bit          chk_en = 0;
  int          done_cnt = 0, done_lat = 0;
  logic [3:0]  log_act[$];
  logic [31:0] log_din[$];
  logic [4:0]  log_idx[$];
  logic [1:0]  log_mi[$];
  int          log_t[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("action", 32'(action), 32'(e_action));
      check("index", 32'(index), 32'(e_index));
      check("mindex", 32'(mindex), 32'(e_mindex));
      check("din", din, e_din);
      check("prog_addr", 32'(prog_addr), 32'(e_addr));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
    end
    if (action != 0) begin
      log_act.push_back(action); log_din.push_back(din); log_idx.push_back(index);
      log_mi.push_back(mindex); log_t.push_back(cyc - s_cap);
    end
    if (done) begin
      done_cnt++;
      done_lat = cyc - s_cap;
    end
  end

  task automatic clear_log();
    log_act.delete(); log_din.delete(); log_idx.delete(); log_mi.delete(); log_t.delete();
    done_cnt = 0;
  endtask

  // mode 0: plain; 1: second start with a new div mid-load; 2: random input churn and start pokes
  task automatic run_seq(input int len, input logic [1:0] mc, input logic [31:0] ex,
                         input logic [23:0] dv, input logic [31:0] gr, input logic [3:0] en,
                         input int mode);
    int n;
    clear_log();
    @(negedge clk);
    plen = 6'(len); mach = mc; exec_ctrl = ex; div_v = dv; pin_grps = gr; en_mask = en;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!done && n < 300) begin
      if (mode == 1 && n == 3) begin
        start = 1; div_v = 24'h123456; plen = 6'd1;
      end else if (mode == 2) begin
        start = ($urandom % 6 == 0); div_v = 24'($urandom); exec_ctrl = $urandom;
        pin_grps = $urandom; en_mask = 4'($urandom); mach = 2'($urandom); plen = 6'($urandom);
      end else begin
        start = 0;
      end
      @(negedge clk);
      n++;
    end
    start = 0;
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done want done within 300 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ea [6];
    logic [31:0] ed [6];
    int n, ninstr, rl;
    for (int i = 0; i < 32; i++) rom[i] = 16'(i);
    repeat (3) @(negedge clk);
    check("rst_action", 32'(action), 0);
    check("rst_din", din, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(prog_addr), 0);
    #2 reset = 0;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // Normal load with literal expectations
    rom[0] = 16'hE081; rom[1] = 16'h0001;
    run_seq(2, 2'd0, 32'h0000_1000, 24'h000280, 32'h0400_0000, 4'h1, 0);
    ea = '{4'd1, 4'd1, 4'd2, 4'd7, 4'd5, 4'd6};
    ed = '{32'h0000E081, 32'h00000001, 32'h00001000, 32'h00000280, 32'h04000000, 32'h00000001};
    check("norm_ncmd", log_act.size(), 6);
    for (int i = 0; i < 6 && i < log_act.size(); i++) begin
      check($sformatf("norm_act%0d", i), 32'(log_act[i]), 32'(ea[i]));
      check($sformatf("norm_din%0d", i), log_din[i], ed[i]);
    end
    if (log_idx.size() >= 2) begin
      check("norm_idx1", 32'(log_idx[1]), 1);
      check("norm_first_t", log_t[0], 2);
    end
    check("norm_done_lat", done_lat, 10);
    check("norm_done_cnt", done_cnt, 1);

    // Zero length
    run_seq(0, 2'd1, 32'hCAFE_0001, 24'hABCDEF, 32'h1234_5678, 4'h2, 0);
    check("zero_ncmd", log_act.size(), 4);
    if (log_act.size() >= 1) begin
      check("zero_first_act", 32'(log_act[0]), 2);
      check("zero_first_t", log_t[0], 2);
    end
    check("zero_done_lat", done_lat, 6);

    // Clamp
    for (int i = 0; i < 32; i++) rom[i] = 16'(i);
    run_seq(40, 2'd2, 32'h1, 24'h2, 32'h3, 4'h4, 0);
    ninstr = 0;
    foreach (log_act[i]) if (log_act[i] == 4'd1) ninstr++;
    check("clamp_ninstr", ninstr, 32);
    check("clamp_ncmd", log_act.size(), 36);
    if (log_act.size() >= 32) begin
      check("clamp_idx31", 32'(log_idx[31]), 31);
      check("clamp_din31", log_din[31], 31);
    end
    check("clamp_done_lat", done_lat, 70);

    // Start while busy
    run_seq(3, 2'd0, 32'h0, 24'h000280, 32'h0, 4'h1, 1);
    if (log_act.size() >= 5) check("busy_div", log_din[4], 32'h00000280);
    check("busy_done_cnt", done_cnt, 1);
    check("busy_done_lat", done_lat, 12);

    // Machine select
    run_seq(1, 2'd3, 32'h5, 24'h6, 32'h7, 4'hF, 0);
    if (log_act.size() >= 5) begin
      check("msel_pend_mi", 32'(log_mi[1]), 3);
      check("msel_div_mi", 32'(log_mi[2]), 3);
      check("msel_grps_mi", 32'(log_mi[3]), 3);
      check("msel_en_din", log_din[4], 32'h0000000F);
    end

    // Reset during the third INSTR, then replay
    clear_log();
    @(negedge clk);
    plen = 6'd5; mach = 2'd1; exec_ctrl = 32'h9; div_v = 24'h8; pin_grps = 32'h7; en_mask = 4'h3;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (log_act.size() < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached", log_act.size(), 3);
    #2 reset = 1;
    #1;
    check("arst_action", 32'(action), 0);
    check("arst_index", 32'(index), 0);
    check("arst_mindex", 32'(mindex), 0);
    check("arst_din", din, 0);
    check("arst_addr", 32'(prog_addr), 0);
    check("arst_busy", 32'(busy), 0);
    @(negedge clk);
    #2 reset = 0;
    run_seq(5, 2'd1, 32'h9, 24'h8, 32'h7, 4'h3, 0);
    check("replay_ncmd", log_act.size(), 9);
    if (log_idx.size() >= 1) check("replay_idx0", 32'(log_idx[0]), 0);
    check("replay_done_lat", done_lat, 16);

    // Randomized sequences, checked every cycle against the model
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
      rl = $urandom_range(0, 40);
      run_seq(rl, 2'($urandom), $urandom, 24'($urandom), $urandom, 4'($urandom), (it % 2) ? 2 : 0);
      check($sformatf("rand%0d_done_lat", it), done_lat, 2 * ((rl > 32) ? 32 : rl) + 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
